// File: rtl/kmap_sweep_checker_pkg.sv
// Shared types and constants for the Kmap sweep checker.
// Contents: sweep FSM state enum, vector count and index width, and the
// packed result record (truth table, mismatch count, first failing index, pass).
package kmap_pkg;

  localparam int KMAP_VECTORS = 16;
  localparam int KMAP_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } kmap_state_t;

  // Everything that is reported at the end of a sweep and held until the
  // next accepted start.
  typedef struct packed {
    logic [KMAP_VECTORS-1:0] truth;
    logic [4:0]              fail_count;
    logic [KMAP_IDX_W-1:0]   first_fail;
    logic                    pass;
  } kmap_result_t;

endpackage

// File: rtl/kmap_sweep_checker_if.sv
// Handshake/result bundle between the sweep checker and its environment.
// slave : checker side (takes start and f_in, drives vector and results).
// master: environment side (drives start and the Kmap output f_in).
interface kmap_sweep_checker_if;

  logic        start;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        f_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;

  modport slave (
    input  start, f_in,
    output a, b, c, d, busy, done, pass, truth, fail_count, first_fail
  );

  modport master (
    output start, f_in,
    input  a, b, c, d, busy, done, pass, truth, fail_count, first_fail
  );

endinterface

// File: rtl/kmap_sweep_checker_settle_timer.sv
// Settle timer: loadable down-counter, o_expired high on the SETTLE-th enabled cycle.
// Ports: clk, rst_n, i_load (reload to SETTLE-1), i_en (count), o_expired.
// Latency: expires on the SETTLE-th enabled cycle after a load; no backpressure.
module kmap_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  // Loading SETTLE-1 makes the zero count coincide with the last hold cycle,
  // so the FSM can leave DRIVE on the same cycle it sees expiry.
  localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_expired = i_en && (r_cnt == 4'd0);

endmodule

// File: rtl/kmap_sweep_checker.sv
// Sweep checker: drives all 16 {a,b,c,d} vectors into a Kmap block, holds each
// SETTLE cycles, samples f_in, and compares against EXPECTED.
// Ports: clk, rst_n (async, active-low), io_chk (slave bundle: start, f_in in;
// a..d, busy, done, pass, truth, fail_count, first_fail out, all registered).
// Latency: done at 16*(SETTLE+1)+1 cycles after start; start ignored while busy.
module kmap_sweep_checker
  import kmap_pkg::*;
#(
  parameter logic [15:0] EXPECTED = 16'h0000,
  parameter int          SETTLE   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  kmap_sweep_checker_if.slave  io_chk
);

  localparam logic [KMAP_IDX_W-1:0] LAST_IDX = KMAP_IDX_W'(KMAP_VECTORS - 1);

  kmap_state_t           r_state;
  kmap_state_t           w_next;
  logic [KMAP_IDX_W-1:0] r_idx;
  kmap_result_t          r_res;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_expired;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_load;
  logic                  w_en;
  logic                  w_mismatch;
  logic [4:0]            w_fail_next;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  assign w_accept    = (r_state == IDLE) && io_chk.start;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_mismatch  = (r_state == SAMPLE) && (io_chk.f_in != EXPECTED[r_idx]);
  assign w_fail_next = r_res.fail_count + 5'(w_mismatch);

  // The timer is reloaded whenever a DRIVE phase is about to begin.
  assign w_load = w_accept || ((r_state == SAMPLE) && !w_last);
  assign w_en   = (r_state == DRIVE);

  kmap_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_en      (w_en),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_chk.start) w_next = DRIVE;
      DRIVE:   if (w_expired)    w_next = SAMPLE;
      SAMPLE:  w_next = w_last ? DONE : DRIVE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode: busy/done are registered, so decode them from the next
  // state to have them line up with the state they describe.
  always_comb begin
    w_busy_nxt = (w_next != IDLE);
    w_done_nxt = (w_next == DONE);
  end

  // Capture, compare and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_idx  <= '0;
      r_res  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      case (r_state)
        IDLE: begin
          if (io_chk.start) begin
            r_idx <= '0;
            r_res <= '0;
          end
        end
        SAMPLE: begin
          r_res.truth[r_idx] <= io_chk.f_in;
          r_res.fail_count   <= w_fail_next;
          // A zero count before this sample means this is the first mismatch.
          if (w_mismatch && (r_res.fail_count == 5'd0)) begin
            r_res.first_fail <= r_idx;
          end
          if (w_last) begin
            // Settled on entry to DONE so pass is valid alongside the done
            // pulse; w_fail_next already folds in the final sample.
            r_res.pass <= (w_fail_next == 5'd0);
          end else begin
            r_idx <= r_idx + KMAP_IDX_W'(1);
          end
        end
        DONE: begin
          r_idx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign io_chk.a          = r_idx[3];
  assign io_chk.b          = r_idx[2];
  assign io_chk.c          = r_idx[1];
  assign io_chk.d          = r_idx[0];
  assign io_chk.busy       = r_busy;
  assign io_chk.done       = r_done;
  assign io_chk.pass       = r_res.pass;
  assign io_chk.truth      = r_res.truth;
  assign io_chk.fail_count = r_res.fail_count;
  assign io_chk.first_fail = r_res.first_fail;

endmodule

// File: doc/kmap_sweep_checker.md
# kmap_sweep_checker

Sequential sweep-and-check stage wrapped around the Karnaugh-map combinational blocks (Kmap1..Kmap3 family). On a start request it drives all 16 input combinations `{a,b,c,d}` into the device under check, waits a programmable settle time per vector, and samples the function output into a 16-bit captured truth table. It compares each sample with an expected truth table and reports pass/fail, mismatch count and first failing index. This puts the testbench's exhaustive sweep in hardware, so any Kmap variant can be self-checked on board or in a system-level simulation.

## Interface
Parameters:
- `EXPECTED`, 16'h0000: expected truth table; bit i is the expected output for `{a,b,c,d} == i`.
- `SETTLE`, 2: cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  sweep request; sampled only in IDLE.
- `a`, `b`, `c`, `d`  out  1 each  vector driven to the Kmap block; `a` is MSB of the index.
- `f_in`  in  1  Kmap block output (`out`).
- `busy`  out  1  high from the first DRIVE cycle through the DONE cycle.
- `done`  out  1  one-cycle pulse when results become valid.
- `pass`  out  1  1 when all 16 samples matched; held until next accepted start.
- `truth`  out  16  captured truth table.
- `fail_count`  out  5  number of mismatches, 0..16.
- `first_fail`  out  4  lowest mismatching index; 0 when `fail_count == 0`.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE with `start == 1`: go to DRIVE. Set idx to 0 and the settle counter to 0. Clear `truth`, `fail_count`, `first_fail` and `pass`.
- DRIVE: `{a,b,c,d} = idx`. The settle counter increments each cycle. After SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE: `{a,b,c,d}` still equals idx. Write `truth[idx] <= f_in`.
  - If `f_in != EXPECTED[idx]`, increment `fail_count`. If this is the first mismatch, latch `first_fail <= idx`.
  - If idx == 15, go to DONE. Otherwise increment idx, reset the settle counter and return to DRIVE.
- DONE: `done = 1` for exactly this cycle. `pass <= (fail_count == 0)`, including any mismatch from the final SAMPLE. Next state is IDLE.
- `start` is ignored in DRIVE, SAMPLE and DONE. There is no queuing. A `start` held continuously relaunches one cycle after DONE.
- idx never wraps inside a sweep. `fail_count` saturates naturally at 16 because 5 bits is enough.
- Results (`truth`, `fail_count`, `first_fail`, `pass`) persist in IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, `a`/`b`/`c`/`d` = 0, `busy` = 0, `done` = 0, `pass` = 0, `truth` = 16'h0000, `fail_count` = 0, `first_fail` = 0.
- Reset asserted mid-sweep aborts immediately to the reset values. There is no partial result.
- All outputs are registered.
- Cycle numbering: `start` is sampled in IDLE at cycle 0.
  - The first DRIVE cycle is cycle 1.
  - Vector i is sampled at cycle (i+1)·(SETTLE+1).
  - `done` is high at cycle 16·(SETTLE+1)+1, which is cycle 49 for SETTLE = 2.
- `f_in` is treated as combinational from `{a,b,c,d}`. It must be stable within SETTLE cycles.

## Structure
- Shared package `kmap_pkg`:
  - state enum `kmap_state_t` {IDLE, DRIVE, SAMPLE, DONE}
  - constant `KMAP_VECTORS = 16`
  - constant `KMAP_IDX_W = 4`
- One natural sub-module, `kmap_settle_timer`: loadable down-counter that asserts `expired` after SETTLE cycles.
- FSM, capture and compare logic stay in the top module.
- The system wrapper instantiates a Kmap block with `.out(f_in)`.

## Test plan
- Correct Kmap model, `EXPECTED = 16'hA5C3`, SETTLE = 2, one start pulse:
  - `{a,b,c,d}` steps 0..15, each held 3 cycles.
  - At cycle 49: `done` pulse, `truth = 16'hA5C3`, `fail_count = 0`, `pass = 1`, `first_fail = 0`.
- Model output inverted: `truth = 16'h5A3C`, `fail_count = 16`, `first_fail = 0`, `pass = 0`.
- Model with a single fault at index 9: `fail_count = 1`, `first_fail = 9`, `pass = 0`, and `truth` differs from `EXPECTED` only in bit 9.
- `start` pulsed again at cycles 10 and 30: both ignored. Exactly one `done` at cycle 49, and `busy` is high for cycles 1..49.
- `rst_n` low for 2 cycles while idx = 7:
  - All outputs return to reset values.
  - A new start completes normally, with `done` 49 cycles after the new start.
- `start` held high continuously: runs go back to back, with `done` at cycles 49, 99 and 149. Results are cleared at the start of each run.
